cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Shares a single common data bus (CDB) between the two execution-side result producers: the ALU path (RS_EX) and the load/store path (LS_EX). Each producer pushes results into a small per-source FIFO. A round-robin scheduler drains one entry per cycle onto a registered CDB. The CDB feeds the ROB, the reservation station, the LSB and the dispatch data-forwarding logic. The block absorbs result collisions, applies back-pressure to the producers, and flushes on ROB rollback.

## Interface
Parameters:
- FIFO_DEPTH, 2: entries per source FIFO; power of two, ≥2.
- DATA_W, 32: result width (matches `DATA_TYPE`).
- ROB_ID_W, 4: ROB tag width (matches `ROB_ID_TYPE`).

Ports:
- clk  in  1  core clock; all state on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- rdy  in  1  core-wide ready; low freezes all state.
- rollback_sign_from_rob  in  1  flush request.
- valid_sign_from_rs_ex  in  1  ALU result valid.
- rob_id_from_rs_ex  in  ROB_ID_W  ALU result tag.
- data_from_rs_ex  in  DATA_W  ALU result value.
- ready_to_rs_ex  out  1  ALU FIFO can accept.
- valid_sign_from_ls_ex  in  1  LS result valid.
- rob_id_from_ls_ex  in  ROB_ID_W  LS result tag.
- data_from_ls_ex  in  DATA_W  LS result value.
- ready_to_ls_ex  out  1  LS FIFO can accept.
- cdb_valid  out  1  broadcast valid.
- cdb_rob_id  out  ROB_ID_W  broadcast tag; `INVALID_ROB` when cdb_valid is low.
- cdb_data  out  DATA_W  broadcast value; 0 when cdb_valid is low.
- cdb_src  out  1  0 = RS_EX, 1 = LS_EX.

## Operation
- **Push:** a source pushes when valid && ready && rdy && !rollback. A valid input while ready is low is a producer protocol violation; the entry is dropped.
- **Ready:** ready_to_x = !full_x && rdy. Ready is not raised by a same-cycle pop; it stays conservative.
- **Scheduler state:** one bit, last_grant (0 = RS, 1 = LS).
  - Both FIFOs non-empty: grant the source ≠ last_grant.
  - Only one FIFO non-empty: grant that source.
  - Neither non-empty: no grant.
  - Any grant updates last_grant.
- **Pop:** the granted FIFO pops its head. The CDB registers load {1, tag, data, src} at the same edge. With no grant, cdb_valid ← 0, cdb_rob_id ← `INVALID_ROB`, cdb_data ← 0.
- **Simultaneous push and pop** on the same FIFO: both occur and the count is unchanged. This is legal when not full.
- **Rollback** (rdy high):
  - Both FIFO pointers and counts clear.
  - CDB registers go to their invalid values.
  - last_grant ← 0.
  - Same-cycle inputs are dropped.
- **rdy low:** nothing pushes or pops; CDB registers hold; ready outputs are 0. Rollback is also ignored while rdy is low.
- **Reset:**
  - FIFOs empty; last_grant = 0.
  - cdb_valid = 0, cdb_rob_id = `INVALID_ROB`, cdb_data = 0, cdb_src = 0.
  - ready outputs = 0 while rst_n is low.
- **FIFO pointers** are log2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH. The count is log2(FIFO_DEPTH)+1 bits.

## Timing
- **Base latency:** push at edge E0 gives the CDB output valid after edge E1, i.e. 2 edges.
- **Throughput:** 1 CDB result per cycle total. Under contention, each source gets one slot every 2 cycles.
- **Rollback:** rollback asserted in cycle C means cdb_valid = 0 from the edge ending C onward. No stale tag is broadcast after that edge.
- **Reset deassertion:** ready rises in the first cycle after rst_n deasserts.

## Configuration
- CDB_BYPASS_EN defined: when a source's FIFO is empty and that source wins arbitration this cycle, its input is written directly to the CDB registers and not into the FIFO.
  - Arbitration in this case treats an incoming valid as non-empty.
  - Latency becomes 1 edge.
  - The losing simultaneous input is pushed normally.
- Undefined: all results pass through the FIFO, with 2-edge latency.

## Structure
- `ROB_ID_TYPE`, `DATA_TYPE` and `INVALID_ROB` come from the shared defines.v. No new global constants are added.
- Sub-module `cdb_fifo` (parameterised depth and width; push, pop, flush; full, empty, head outputs) is instantiated twice. Arbitration and the CDB registers stay in cdb_arbiter.

## Test plan
- **Reset:** hold rst_n low with inputs active → cdb_valid=0, cdb_rob_id=`INVALID_ROB`, ready_*=0. Release → ready_*=1 next cycle.
- **Single result:** RS push tag 3, data 0x55 at E0 → after E1: cdb_valid=1, tag 3, 0x55, src 0. One cycle later cdb_valid=0. With CDB_BYPASS_EN the same values appear after E0.
- **Contention:** both sources push every cycle (RS tags 1,2,…; LS tags 9,10,…) → CDB order RS1, LS9, RS2, LS10, …. ready_* falls once each FIFO holds FIFO_DEPTH entries.
- **Back-pressure:** DEPTH=2, both sources streaming → after the FIFOs fill, ready toggles so no entry is lost. Every pushed tag appears exactly once.
- **Rollback:** 2 entries queued plus a new input in the rollback cycle → cdb_valid=0 next edge. No queued or new tag is ever broadcast. ready_*=1.
- **Freeze:** rdy low for 3 cycles with 1 entry queued and cdb_valid=1 → CDB outputs and FIFO contents are unchanged. Drain resumes on the first rdy-high edge.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter shared types: result source ids and the round-robin pick.
// Imported by cdb_arbiter; cdb_fifo is type-agnostic.
package cdb_arbiter_pkg;

  typedef enum logic {
    SRC_RS = 1'b0,
    SRC_LS = 1'b1
  } src_e;

  typedef struct packed {
    logic vld;
    src_e src;
  } grant_t;

  // Both contenders: take the one not served last.
  function automatic grant_t rr_pick(
    input logic av_rs,
    input logic av_ls,
    input src_e last
  );
    grant_t g;
    g.vld = av_rs | av_ls;
    if (av_rs && av_ls) begin
      g.src = (last == SRC_RS) ? SRC_LS : SRC_RS;
    end else begin
      g.src = av_ls ? SRC_LS : SRC_RS;
    end
    return g;
  endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Small power-of-two FIFO, one per result source.
// Ports: push/pop/flush in, din in; full/empty/head out.
module cdb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 36
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] P_ONE = 1;
  localparam logic [PW:0]   C_ONE = 1;
  localparam logic [PW:0]   C_FULL = (PW+1)'(DEPTH);

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    mem_d  = mem_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) begin
        mem_d[wptr_q] = din;
        wptr_d = wptr_q + P_ONE;
      end
      if (pop) begin
        rptr_d = rptr_q + P_ONE;
      end
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + C_ONE;
        2'b01:   cnt_d = cnt_q - C_ONE;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      mem_q  <= mem_d;
    end
  end

  assign full  = (cnt_q == C_FULL);
  assign empty = (cnt_q == '0);
  assign head  = mem_q[rptr_q];

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin merge of ALU and LS results onto a registered CDB.
// Ports: rs/ls valid,tag,data in + ready out; cdb_* out. Macro: CDB_BYPASS_EN.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int DATA_W     = 32,
  parameter int ROB_ID_W   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rdy,
  input  logic                rollback_sign_from_rob,
  input  logic                valid_sign_from_rs_ex,
  input  logic [ROB_ID_W-1:0] rob_id_from_rs_ex,
  input  logic [DATA_W-1:0]   data_from_rs_ex,
  output logic                ready_to_rs_ex,
  input  logic                valid_sign_from_ls_ex,
  input  logic [ROB_ID_W-1:0] rob_id_from_ls_ex,
  input  logic [DATA_W-1:0]   data_from_ls_ex,
  output logic                ready_to_ls_ex,
  output logic                cdb_valid,
  output logic [ROB_ID_W-1:0] cdb_rob_id,
  output logic [DATA_W-1:0]   cdb_data,
  output logic                cdb_src
);

  localparam int EW = ROB_ID_W + DATA_W;
  // Unused tag value marking an idle bus.
  localparam logic [ROB_ID_W-1:0] INVALID_ROB = '1;

  logic          full_rs, empty_rs;
  logic          full_ls, empty_ls;
  logic [EW-1:0] head_rs, head_ls;
  logic [EW-1:0] in_rs, in_ls, win;
  logic          act, flush;
  logic          acc_rs, acc_ls;
  logic          av_rs, av_ls;
  logic          sel_rs, sel_ls;
  logic          byp_rs, byp_ls;
  logic          push_rs, push_ls;
  logic          pop_rs, pop_ls;
  grant_t        gnt;

  // Holds ready low until the first edge after reset release.
  logic          en_q, en_d;
  src_e          last_q, last_d;
  logic          cv_q, cv_d;
  logic [ROB_ID_W-1:0] ctag_q, ctag_d;
  logic [DATA_W-1:0]   cdat_q, cdat_d;
  src_e          csrc_q, csrc_d;

  assign in_rs = {rob_id_from_rs_ex, data_from_rs_ex};
  assign in_ls = {rob_id_from_ls_ex, data_from_ls_ex};

  assign ready_to_rs_ex = en_q & rdy & ~full_rs;
  assign ready_to_ls_ex = en_q & rdy & ~full_ls;

  assign act   = rdy & ~rollback_sign_from_rob;
  assign flush = rdy & rollback_sign_from_rob;

  assign acc_rs = valid_sign_from_rs_ex & ready_to_rs_ex
                & ~rollback_sign_from_rob;
  assign acc_ls = valid_sign_from_ls_ex & ready_to_ls_ex
                & ~rollback_sign_from_rob;

`ifdef CDB_BYPASS_EN
  assign av_rs = ~empty_rs | acc_rs;
  assign av_ls = ~empty_ls | acc_ls;
`else
  assign av_rs = ~empty_rs;
  assign av_ls = ~empty_ls;
`endif

  assign gnt    = rr_pick(av_rs, av_ls, last_q);
  assign sel_rs = act & gnt.vld & (gnt.src == SRC_RS);
  assign sel_ls = act & gnt.vld & (gnt.src == SRC_LS);

`ifdef CDB_BYPASS_EN
  // An empty FIFO can only win through its live input.
  assign byp_rs = sel_rs & empty_rs;
  assign byp_ls = sel_ls & empty_ls;
`else
  assign byp_rs = 1'b0;
  assign byp_ls = 1'b0;
`endif

  assign push_rs = acc_rs & ~byp_rs;
  assign push_ls = acc_ls & ~byp_ls;
  assign pop_rs  = sel_rs & ~byp_rs;
  assign pop_ls  = sel_ls & ~byp_ls;

  cdb_fifo #(.DEPTH(FIFO_DEPTH), .W(EW)) u_fifo_rs (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_rs),
    .pop   (pop_rs),
    .flush (flush),
    .din   (in_rs),
    .full  (full_rs),
    .empty (empty_rs),
    .head  (head_rs)
  );

  cdb_fifo #(.DEPTH(FIFO_DEPTH), .W(EW)) u_fifo_ls (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_ls),
    .pop   (pop_ls),
    .flush (flush),
    .din   (in_ls),
    .full  (full_ls),
    .empty (empty_ls),
    .head  (head_ls)
  );

  always_comb begin
    win = head_rs;
    if (sel_ls) begin
      win = byp_ls ? in_ls : head_ls;
    end else if (byp_rs) begin
      win = in_rs;
    end
  end

  always_comb begin
    en_d   = 1'b1;
    last_d = last_q;
    cv_d   = cv_q;
    ctag_d = ctag_q;
    cdat_d = cdat_q;
    csrc_d = csrc_q;
    if (flush) begin
      cv_d   = 1'b0;
      ctag_d = INVALID_ROB;
      cdat_d = '0;
      last_d = SRC_RS;
    end else if (act && gnt.vld) begin
      cv_d   = 1'b1;
      ctag_d = win[EW-1:DATA_W];
      cdat_d = win[DATA_W-1:0];
      csrc_d = gnt.src;
      last_d = gnt.src;
    end else if (act) begin
      cv_d   = 1'b0;
      ctag_d = INVALID_ROB;
      cdat_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q   <= 1'b0;
      last_q <= SRC_RS;
      cv_q   <= 1'b0;
      ctag_q <= INVALID_ROB;
      cdat_q <= '0;
      csrc_q <= SRC_RS;
    end else begin
      en_q   <= en_d;
      last_q <= last_d;
      cv_q   <= cv_d;
      ctag_q <= ctag_d;
      cdat_q <= cdat_d;
      csrc_q <= csrc_d;
    end
  end

  assign cdb_valid  = cv_q;
  assign cdb_rob_id = ctag_q;
  assign cdb_data   = cdat_q;
  assign cdb_src    = csrc_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter (default build, FIFO_DEPTH=2).
// Covers reset, latency, contention, back-pressure, rollback, freeze.
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy;
  logic        rb;
  logic        v_rs, v_ls;
  logic [3:0]  t_rs, t_ls;
  logic [31:0] d_rs, d_ls;
  logic        r_rs, r_ls;
  logic        cv;
  logic [3:0]  ctag;
  logic [31:0] cdat;
  logic        csrc;

  int vec = 0;
  int err = 0;

  cdb_arbiter #(
    .FIFO_DEPTH(2),
    .DATA_W(32),
    .ROB_ID_W(4)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .rdy                    (rdy),
    .rollback_sign_from_rob (rb),
    .valid_sign_from_rs_ex  (v_rs),
    .rob_id_from_rs_ex      (t_rs),
    .data_from_rs_ex        (d_rs),
    .ready_to_rs_ex         (r_rs),
    .valid_sign_from_ls_ex  (v_ls),
    .rob_id_from_ls_ex      (t_ls),
    .data_from_ls_ex        (d_ls),
    .ready_to_ls_ex         (r_ls),
    .cdb_valid              (cv),
    .cdb_rob_id             (ctag),
    .cdb_data               (cdat),
    .cdb_src                (csrc)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       nm,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    vec++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s: got %0h want %0h", nm, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cdb(input string nm);
    chk({nm, "_v"}, {31'b0, cv}, 32'd0);
    chk({nm, "_tag"}, {28'b0, ctag}, 32'hF);
    chk({nm, "_dat"}, cdat, 32'd0);
  endtask

  task automatic hit(
    input string      nm,
    input logic [3:0] tag,
    input logic [31:0] dat,
    input logic       src
  );
    chk({nm, "_v"}, {31'b0, cv}, 32'd1);
    chk({nm, "_tag"}, {28'b0, ctag}, {28'b0, tag});
    chk({nm, "_dat"}, cdat, dat);
    chk({nm, "_src"}, {31'b0, csrc}, {31'b0, src});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rs_t;
    int ls_t;
    int j;
    logic er, el;
    logic [3:0] et;

    rst_n = 1'b0;
    rdy   = 1'b1;
    rb    = 1'b0;
    v_rs  = 1'b1;
    v_ls  = 1'b1;
    t_rs  = 4'd7;
    t_ls  = 4'd8;
    d_rs  = 32'h1234;
    d_ls  = 32'h5678;

    #12;
    idle_cdb("rst");
    chk("rst_rdy_rs", {31'b0, r_rs}, 32'd0);
    chk("rst_rdy_ls", {31'b0, r_ls}, 32'd0);
    #1;
    rst_n = 1'b1;
    v_rs  = 1'b0;
    v_ls  = 1'b0;
    step();
    chk("rel_rdy_rs", {31'b0, r_rs}, 32'd1);
    chk("rel_rdy_ls", {31'b0, r_ls}, 32'd1);
    idle_cdb("rel");

    // single RS result: visible two edges after the push
    v_rs = 1'b1;
    t_rs = 4'd3;
    d_rs = 32'h55;
    step();
    v_rs = 1'b0;
    chk("one_e0_v", {31'b0, cv}, 32'd0);
    step();
    hit("one_e1", 4'd3, 32'h55, 1'b0);
    step();
    idle_cdb("one_e2");

    // single LS result; leaves last_grant on LS
    v_ls = 1'b1;
    t_ls = 4'd5;
    d_ls = 32'h77;
    step();
    v_ls = 1'b0;
    step();
    hit("ls1", 4'd5, 32'h77, 1'b1);
    step();

    // contention with back-pressure
    rs_t = 1;
    ls_t = 9;
    for (int k = 0; k < 10; k++) begin
      er = (k < 2) || (k % 2 == 0);
      el = (k < 2) || (k % 2 == 1);
      chk("ct_rdy_rs", {31'b0, r_rs}, {31'b0, er});
      chk("ct_rdy_ls", {31'b0, r_ls}, {31'b0, el});
      v_rs = 1'b1;
      t_rs = 4'(rs_t);
      d_rs = 32'hA000_0000 | rs_t;
      v_ls = 1'b1;
      t_ls = 4'(ls_t);
      d_ls = 32'hB000_0000 | ls_t;
      step();
      if (er) rs_t++;
      if (el) ls_t++;
      if (k >= 1) begin
        j = k - 1;
        if (j % 2 == 0) begin
          et = 4'(1 + j / 2);
          hit("ct", et, 32'hA000_0000 | et, 1'b0);
        end else begin
          et = 4'(9 + j / 2);
          hit("ct", et, 32'hB000_0000 | et, 1'b1);
        end
      end
    end

    // rollback with entries queued and new inputs present
    rb = 1'b1;
    step();
    rb   = 1'b0;
    v_rs = 1'b0;
    v_ls = 1'b0;
    idle_cdb("rb_e0");
    chk("rb_rdy_rs", {31'b0, r_rs}, 32'd1);
    chk("rb_rdy_ls", {31'b0, r_ls}, 32'd1);
    step();
    idle_cdb("rb_e1");
    step();
    idle_cdb("rb_e2");

    // last_grant cleared by rollback: LS wins the tie
    v_rs = 1'b1;
    t_rs = 4'd2;
    d_rs = 32'h22;
    v_ls = 1'b1;
    t_ls = 4'd6;
    d_ls = 32'h66;
    step();
    v_rs = 1'b0;
    v_ls = 1'b0;
    step();
    hit("tie", 4'd6, 32'h66, 1'b1);

    // freeze with RS tag 2 still queued
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      hit("frz", 4'd6, 32'h66, 1'b1);
      chk("frz_rdy_rs", {31'b0, r_rs}, 32'd0);
      chk("frz_rdy_ls", {31'b0, r_ls}, 32'd0);
    end
    rdy = 1'b1;
    step();
    hit("thaw", 4'd2, 32'h22, 1'b0);
    step();
    idle_cdb("drain");

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
